muldiv_iter: RTL and testbench

- Iterative RV32M multiply/divide unit that sits beside the single-cycle integer ALU in the execute stage.
- It takes the operand pair and funct3 when the core issues an M-extension instruction.
- It computes the product or quotient/remainder over multiple cycles and returns a 32-bit result through a valid/ready handshake.
- The core stalls on `in_ready`/`out_valid`.

---
 rtl/muldiv_iter.sv | 162 ++++++++++++++++
 tb/tb_muldiv_iter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide
// on operand magnitudes, with a one-cycle sign fix-up and a valid/ready result port.
module muldiv_iter #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(ITER);
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic            negA_q, negA_d, negB_q, negB_d;
    logic [XLEN-1:0] mag_q, mag_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            signAIn, signBIn, divZero, divOvf;
    logic [XLEN-1:0] magAIn, magBIn, fastRes;
    logic [XLEN:0]   mulSum, divShift, divDiff;
    logic [2*XLEN-1:0] prodRaw, prodFix;
    logic [XLEN-1:0] quoFix, remFix, fixRes;

    // Signedness per funct3: MULH/DIV/REM signed x signed, MULHSU signed x unsigned.
    assign signAIn = a[XLEN-1] && (op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd6);
    assign signBIn = b[XLEN-1] && (op == 3'd1 || op == 3'd4 || op == 3'd6);
    assign magAIn  = signAIn ? -a : a;
    assign magBIn  = signBIn ? -b : b;

    assign divZero = (b == '0);
    assign divOvf  = !op[0] && (a == MINV) && (b == '1);
    assign fastRes = divZero ? (op[1] ? a : '1) : (op[1] ? '0 : MINV);

    // hi/lo hold the running product for multiplies, remainder/quotient for divides.
    assign mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
    assign divShift = {hi_q, lo_q[XLEN-1]};
    assign divDiff  = divShift - {1'b0, mag_q};

    assign prodRaw = {hi_q, lo_q};
    assign prodFix = (negA_q ^ negB_q) ? -prodRaw : prodRaw;
    assign quoFix  = (negA_q ^ negB_q) ? -lo_q : lo_q;
    assign remFix  = negA_q ? -hi_q : hi_q;

    always_comb begin
        fixRes = remFix;
        case (op_q)
            3'd0:                fixRes = prodFix[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    fixRes = prodFix[2*XLEN-1:XLEN];
            3'd4, 3'd5:          fixRes = quoFix;
            default:             fixRes = remFix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            negA_q   <= 1'b0;
            negB_q   <= 1'b0;
            mag_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            negA_q   <= negA_d;
            negB_q   <= negB_d;
            mag_q    <= mag_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        negA_d   = negA_q;
        negB_d   = negB_q;
        mag_d    = mag_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    op_d   = op;
                    negA_d = signAIn;
                    negB_d = signBIn;
                    cnt_d  = '0;
                    hi_d   = '0;
                    lo_d   = op[2] ? magAIn : magBIn;
                    mag_d  = op[2] ? magBIn : magAIn;
                    if (op[2] && (divZero || divOvf)) begin
                        result_d = fastRes;
                        state_d  = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (op_q[2]) begin
                        hi_d = divDiff[XLEN] ? divShift[XLEN-1:0] : divDiff[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], !divDiff[XLEN]};
                    end else begin
                        hi_d = mulSum[XLEN:1];
                        lo_d = {mulSum[0], lo_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(ITER - 1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    result_d = fixRes;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (flush || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == CALC) || (state_q == FIX);
    assign result    = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: directed RV32M cases, fast paths, backpressure,
// flush and asynchronous reset, plus a few randomized operations against a reference model.
module tb_muldiv_iter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int vectors;
    int miscompares;
    logic [31:0] expQ[$];

    muldiv_iter #(.XLEN(32), .ITER(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] refModel(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, sp;
        logic [63:0] up;
        logic [31:0] r;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        r = '0;
        case (o)
            3'd0: begin up = {32'b0, x} * {32'b0, y}; r = up[31:0]; end
            3'd1: begin sp = sx * sy; r = sp[63:32]; end
            3'd2: begin sp = sx * $signed({32'b0, y}); r = sp[63:32]; end
            3'd3: begin up = {32'b0, x} * {32'b0, y}; r = up[63:32]; end
            3'd4: begin
                if (y == 0) r = 32'hFFFFFFFF;
                else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = 32'h80000000;
                else r = $signed(x) / $signed(y);
            end
            3'd5: r = (y == 0) ? 32'hFFFFFFFF : x / y;
            3'd6: begin
                if (y == 0) r = x;
                else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = 32'h0;
                else r = $signed(x) % $signed(y);
            end
            default: r = (y == 0) ? x : x % y;
        endcase
        return r;
    endfunction

    // Drives one request and returns once it has been accepted at a rising edge.
    task automatic acceptOnly(input logic [2:0] opV, input logic [31:0] aV, input logic [31:0] bV, input string name);
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL %s in_ready before accept: got %b want 1", name, in_ready);
        end
        in_valid = 1'b1;
        op = opV;
        a = aV;
        b = bV;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic runOp(input logic [2:0] opV, input logic [31:0] aV, input logic [31:0] bV,
                         input logic [31:0] expV, input int expLat, input int holdCycles, input string name);
        int n;
        bit seen;
        logic [31:0] want;
        logic [31:0] got;
        acceptOnly(opV, aV, bV, name);
        expQ.push_back(expV);
        seen = 1'b0;
        n = 0;
        while (!seen && n < 100) begin
            n++;
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1'b1;
            else if (n == 1 && expLat > 1) begin
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL %s busy in CALC: got %b want 1", name, busy);
                end
            end
        end
        want = expQ.pop_front();
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("[TB] FAIL %s timeout: out_valid never rose within 100 cycles", name);
            return;
        end
        got = result;
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s result: got %h want %h", name, got, want);
        end
        vectors++;
        if (n != expLat) begin
            miscompares++;
            $display("[TB] FAIL %s latency: got %0d want %0d", name, n, expLat);
        end
        vectors++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s DONE flags: in_ready %b busy %b want 0 0", name, in_ready, busy);
        end
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (out_valid !== 1'b1 || result !== got || in_ready !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL %s hold %0d: out_valid %b result %h in_ready %b want 1 %h 0",
                         name, i, out_valid, result, in_ready, got);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL %s release: out_valid %b in_ready %b want 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic expectQuiet(input int cycles, input string name);
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("[TB] FAIL %s stale out_valid: got 1 want 0", name);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset: in_ready %b out_valid %b busy %b result %h want 1 0 0 0",
                     in_ready, out_valid, busy, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        runOp(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0, "MUL");
        runOp(3'd1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 33, 0, "MULH");
        runOp(3'd3, 32'd7, 32'hFFFFFFFD, 32'h00000006, 33, 0, "MULHU");
        runOp(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 0, "MULHSU");
        runOp(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0, "MULHU_max");
    endtask

    task automatic test_div();
        runOp(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 0, "DIV");
        runOp(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 0, "REM");
        runOp(3'd5, 32'd100, 32'd7, 32'd14, 33, 0, "DIVU");
        runOp(3'd7, 32'd100, 32'd7, 32'd2, 33, 0, "REMU");
    endtask

    task automatic test_fastpath();
        runOp(3'd4, 32'h12345678, 32'h0, 32'hFFFFFFFF, 1, 0, "DIV_by0");
        runOp(3'd5, 32'h12345678, 32'h0, 32'hFFFFFFFF, 1, 0, "DIVU_by0");
        runOp(3'd6, 32'h12345678, 32'h0, 32'h12345678, 1, 0, "REM_by0");
        runOp(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0, "DIV_ovf");
        runOp(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 0, "REM_ovf");
    endtask

    task automatic test_back_to_back();
        runOp(3'd0, 32'h00012345, 32'h00000100, 32'h01234500, 33, 5, "B2B_first");
        runOp(3'd5, 32'hDEADBEEF, 32'h00001000, 32'h000DEADB, 33, 0, "B2B_second");
    endtask

    task automatic test_random();
        logic [2:0] o;
        logic [31:0] x, y;
        int lat;
        for (int i = 0; i < 8; i++) begin
            o = 3'(i);
            x = $urandom;
            y = (i == 5) ? 32'h0 : $urandom;
            lat = (o[2] && (y == 0 || (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF))) ? 1 : 33;
            runOp(o, x, y, refModel(o, x, y), lat, 0, "random");
        end
    endtask

    task automatic test_flush();
        acceptOnly(3'd0, 32'd9, 32'd9, "flush_calc");
        for (int i = 0; i < 9; i++) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_calc: in_ready %b busy %b out_valid %b want 1 0 0", in_ready, busy, out_valid);
        end
        expectQuiet(40, "flush_calc");

        @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1;
        op = 3'd5;
        a = 32'h1;
        b = 32'h0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL flush_idle: out_valid %b in_ready %b want 0 1", out_valid, in_ready);
        end

        acceptOnly(3'd5, 32'h1, 32'h0, "flush_done");
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL flush_done: out_valid %b in_ready %b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_async_reset();
        acceptOnly(3'd4, 32'd1000, 32'd3, "async_reset");
        for (int i = 0; i < 19; i++) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: in_ready %b out_valid %b busy %b result %h want 1 0 0 0",
                     in_ready, out_valid, busy, result);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        expectQuiet(40, "async_reset");
        runOp(3'd5, 32'd1000, 32'd3, 32'd333, 33, 0, "post_reset");
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        in_valid = 1'b0;
        op = 3'd0;
        a = '0;
        b = '0;
        flush = 1'b0;
        out_ready = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_fastpath();
        test_back_to_back();
        test_random();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
